// File: rtl/mem_arbiter_pkg.sv
// Shared types for the core memory-port arbiter.
// States, grant encodings and the grant decode helper.
package mem_arbiter_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_GRANT_F = 3'd1,
    S_GRANT_D = 3'd2,
    S_RELEASE = 3'd3,
    S_ABORT   = 3'd4
  } state_e;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_F    = 2'b01;
  localparam logic [1:0] GNT_D    = 2'b10;

  // An aborting transaction still shows its owner on grant.
  function automatic logic [1:0] gnt_of(
    input state_e s,
    input logic   own_d
  );
    logic [1:0] g;
    g = GNT_NONE;
    unique case (s)
      S_GRANT_F: g = GNT_F;
      S_GRANT_D: g = GNT_D;
      S_ABORT:   g = own_d ? GNT_D : GNT_F;
      default:   g = GNT_NONE;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick over {D,F}.
// On a tie the port that did not win last time is chosen.
module rr_arbiter2
  import mem_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       update,
  input  logic [1:0] upd_gnt,
  output logic [1:0] pick
);

  logic [1:0] last_q;

  // Remember the last served port; F after reset so D wins a tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= GNT_F;
    end else if (update) begin
      last_q <= upd_gnt;
    end
  end

  // Single requester wins outright; a tie goes to the other port.
  always_comb begin
    pick = GNT_NONE;
    unique case (1'b1)
      (req == 2'b11): pick = ~last_q;
      (req == 2'b10): pick = GNT_D;
      (req == 2'b01): pick = GNT_F;
      default:        pick = GNT_NONE;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the memory port between fetch (F) and LSU (D).
// Round-robin grant, 4-phase handshake, watchdog abort.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 32,
  parameter int BYTE_DATA_WIDTH = 4,
  parameter int TIMEOUT         = 255,
  parameter int CNT_WIDTH       = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       f_req,
  input  logic [ADDR_WIDTH-1:0]      f_addr,
  output logic                       f_valid,
  input  logic                       d_req,
  input  logic                       d_we,
  input  logic [ADDR_WIDTH-1:0]      d_addr,
  input  logic [DATA_WIDTH-1:0]      d_wdata,
  input  logic [BYTE_DATA_WIDTH-1:0] d_byte_enable,
  output logic                       d_valid,
  output logic [DATA_WIDTH-1:0]      rdata,
  output logic                       mem_req,
  output logic                       mem_we,
  output logic [ADDR_WIDTH-1:0]      mem_addr,
  output logic [DATA_WIDTH-1:0]      mem_wdata,
  output logic [BYTE_DATA_WIDTH-1:0] mem_byte_enable,
  input  logic [DATA_WIDTH-1:0]      mem_rdata,
  input  logic                       mem_valid,
  output logic [1:0]                 grant,
  output logic                       err_timeout
);

  localparam logic [CNT_WIDTH-1:0] TO =
    CNT_WIDTH'(TIMEOUT);
  localparam bit WD_EN = (TIMEOUT != 0);

  logic [1:0]           rst_q;
  logic                 rst_i;
  state_e               state_q, state_d;
  logic                 own_d_q, own_d_d;
  logic                 seen_q, seen_d;
  logic                 done_q, done_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 err_q, err_d;
  logic [1:0]           grant_q;
  logic [1:0]           pick;
  logic                 upd;
  logic                 cur_req;
  logic [1:0]           own_gnt;

  // Reset asserts at once, releases two edges after rst_n rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_q <= 2'b00;
    end else begin
      rst_q <= {rst_q[0], 1'b1};
    end
  end

  assign rst_i   = rst_q[1];
  assign cur_req = own_d_q ? d_req : f_req;
  assign own_gnt = own_d_q ? GNT_D : GNT_F;

  rr_arbiter2 u_rr (
    .clk     (clk),
    .rst_n   (rst_i),
    .req     ({d_req, f_req}),
    .update  (upd),
    .upd_gnt (own_gnt),
    .pick    (pick)
  );

  // State and bookkeeping registers; grant mirrors the next state.
  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
      own_d_q <= 1'b0;
      seen_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      grant_q <= GNT_NONE;
    end else begin
      state_q <= state_d;
      own_d_q <= own_d_d;
      seen_q  <= seen_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      grant_q <= gnt_of(state_d, own_d_d);
    end
  end

  // Next state: arbitration, completion and watchdog.
  always_comb begin
    state_d = state_q;
    own_d_d = own_d_q;
    seen_d  = seen_q;
    done_d  = done_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    upd     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        seen_d = 1'b0;
        done_d = 1'b0;
        cnt_d  = '0;
        unique case (1'b1)
          (pick == GNT_D): begin
            state_d = S_GRANT_D;
            own_d_d = 1'b1;
          end
          (pick == GNT_F): begin
            state_d = S_GRANT_F;
            own_d_d = 1'b0;
          end
          default: state_d = S_IDLE;
        endcase
      end
      S_GRANT_F, S_GRANT_D: begin
        if (mem_valid) seen_d = 1'b1;
        // Once req has dropped, a re-raise belongs to the next round.
        if (!cur_req) done_d = 1'b1;
        if ((done_q || !cur_req) && !mem_valid) begin
          state_d = S_RELEASE;
          upd     = 1'b1;
        end else if (WD_EN && !seen_q && !mem_valid) begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
          if (cnt_d == TO) begin
            state_d = S_ABORT;
            err_d   = 1'b1;
          end
        end
      end
      S_ABORT: begin
        if (!cur_req) begin
          state_d = S_RELEASE;
          upd     = 1'b1;
        end
      end
      S_RELEASE: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Memory mux and response routing for the current owner.
  always_comb begin
    mem_req         = 1'b0;
    mem_we          = 1'b0;
    mem_addr        = '0;
    mem_wdata       = '0;
    mem_byte_enable = '0;
    f_valid         = 1'b0;
    d_valid         = 1'b0;
    rdata           = '0;
    unique case (state_q)
      S_GRANT_F: begin
        mem_req         = f_req && !done_q;
        mem_addr        = f_addr;
        mem_byte_enable = '1;
        f_valid         = mem_valid;
        rdata           = mem_rdata;
      end
      S_GRANT_D: begin
        mem_req         = d_req && !done_q;
        mem_we          = d_we;
        mem_addr        = d_addr;
        mem_wdata       = d_wdata;
        mem_byte_enable = d_byte_enable;
        d_valid         = mem_valid;
        rdata           = mem_rdata;
      end
      S_ABORT: begin
        f_valid = !own_d_q;
        d_valid = own_d_q;
      end
      default: begin
      end
    endcase
  end

  assign grant       = grant_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter.
// Memory model answers 3 cycles after mem_req.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        f_req;
  logic [31:0] f_addr;
  logic        f_valid;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_byte_enable;
  logic        d_valid;
  logic [31:0] rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_byte_enable;
  logic [31:0] mem_rdata;
  logic        mem_valid;
  logic [1:0]  grant;
  logic        err_timeout;

  int n_checks;
  int n_fail;
  bit mem_silent;
  int lat_cnt;
  bit mon_en;

  logic [31:0] exp_f[$];
  logic [31:0] exp_d[$];
  logic [1:0]  exp_gnt[$];
  logic [1:0]  obs_gnt[$];
  int          gaps[$];

  mem_arbiter #(
    .DATA_WIDTH      (32),
    .ADDR_WIDTH      (32),
    .BYTE_DATA_WIDTH (4),
    .TIMEOUT         (4),
    .CNT_WIDTH       (8)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .f_req           (f_req),
    .f_addr          (f_addr),
    .f_valid         (f_valid),
    .d_req           (d_req),
    .d_we            (d_we),
    .d_addr          (d_addr),
    .d_wdata         (d_wdata),
    .d_byte_enable   (d_byte_enable),
    .d_valid         (d_valid),
    .rdata           (rdata),
    .mem_req         (mem_req),
    .mem_we          (mem_we),
    .mem_addr        (mem_addr),
    .mem_wdata       (mem_wdata),
    .mem_byte_enable (mem_byte_enable),
    .mem_rdata       (mem_rdata),
    .mem_valid       (mem_valid),
    .grant           (grant),
    .err_timeout     (err_timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mdata(input logic [31:0] a);
    if (a == 32'h100) return 32'hDEAD_BEEF;
    return a ^ 32'h5A5A_0000;
  endfunction

  // Memory: valid 3 cycles after req, drops once req drops.
  initial begin
    mem_valid = 1'b0;
    mem_rdata = '0;
    lat_cnt   = 0;
    forever begin
      @(posedge clk);
      #2;
      if (mem_silent) begin
        lat_cnt = 0;
      end else if (!mem_req) begin
        lat_cnt = 0;
        if (mem_valid) mem_valid = 1'b0;
      end else if (!mem_valid) begin
        lat_cnt++;
        if (lat_cnt == 3) begin
          mem_valid = 1'b1;
          mem_rdata = mdata(mem_addr);
        end
      end
    end
  end

  // Grant monitor: order of grants and idle gaps between them.
  initial begin
    logic [1:0] prev;
    int zrun;
    bit started;
    prev = 2'b00;
    zrun = 0;
    started = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (grant == 2'b00) begin
          zrun++;
        end else if (prev == 2'b00) begin
          obs_gnt.push_back(grant);
          if (started) gaps.push_back(zrun);
          started = 1'b1;
          zrun = 0;
        end
        prev = grant;
      end else begin
        prev = 2'b00;
        zrun = 0;
        started = 1'b0;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout sim did not finish");
    $fatal(1);
  end

  task automatic apply_reset();
    rst_n = 1'b0;
    f_req = 1'b0;
    d_req = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic f_txn(
    input  logic [31:0] a,
    output bit          ok,
    output logic [31:0] rd,
    output bit          mir,
    output logic        dv,
    output logic        we,
    output logic [3:0]  be,
    output logic [31:0] ma
  );
    int n;
    f_addr = a;
    f_req  = 1'b1;
    ok = 1'b0;
    n  = 0;
    while (n < 60 && !ok) begin
      @(negedge clk);
      n++;
      if (f_valid) ok = 1'b1;
    end
    rd  = rdata;
    mir = (f_valid === mem_valid);
    dv  = d_valid;
    we  = mem_we;
    be  = mem_byte_enable;
    ma  = mem_addr;
    f_req = 1'b0;
    n = 0;
    while (n < 60 && f_valid) begin
      @(negedge clk);
      n++;
    end
    if (f_valid) ok = 1'b0;
  endtask

  task automatic d_txn(
    input  logic        w,
    input  logic [31:0] a,
    input  logic [31:0] wd,
    input  logic [3:0]  be_i,
    output bit          ok,
    output logic [31:0] rd,
    output logic        fv,
    output logic        mwe,
    output logic [31:0] ma,
    output logic [31:0] mwd,
    output logic [3:0]  mbe
  );
    int n;
    d_we  = w;
    d_addr = a;
    d_wdata = wd;
    d_byte_enable = be_i;
    d_req = 1'b1;
    ok = 1'b0;
    n  = 0;
    while (n < 60 && !ok) begin
      @(negedge clk);
      n++;
      if (d_valid) ok = 1'b1;
    end
    rd  = rdata;
    fv  = f_valid;
    mwe = mem_we;
    ma  = mem_addr;
    mwd = mem_wdata;
    mbe = mem_byte_enable;
    d_req = 1'b0;
    n = 0;
    while (n < 60 && d_valid) begin
      @(negedge clk);
      n++;
    end
    if (d_valid) ok = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    rst_n = 1'b0;
    f_req = 1'b1;
    f_addr = 32'h0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({mem_req, mem_we, f_valid, d_valid, err_timeout} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctl got=%b exp=00000",
        {mem_req, mem_we, f_valid, d_valid, err_timeout});
    end
    n_checks++;
    if (grant !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_grant got=%b exp=00", grant);
    end
    n_checks++;
    if ({rdata, mem_addr, mem_wdata, mem_byte_enable} !== 100'b0) begin
      n_fail++;
      $display("FAIL reset_bus got=%h/%h/%h/%h exp=0",
        rdata, mem_addr, mem_wdata, mem_byte_enable);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (mem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL rel_cyc1 mem_req got=%b exp=0", mem_req);
    end
    @(negedge clk);
    n_checks++;
    if (mem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL rel_cyc2 mem_req got=%b exp=0", mem_req);
    end
    @(negedge clk);
    n_checks++;
    if (mem_req !== 1'b1 || grant !== GNT_F) begin
      n_fail++;
      $display("FAIL rel_cyc3 got req=%b gnt=%b exp req=1 gnt=01",
        mem_req, grant);
    end
    n = 0;
    while (n < 60 && !f_valid) begin
      @(negedge clk);
      n++;
    end
    f_req = 1'b0;
    while (n < 120 && f_valid) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (n >= 60) begin
      n_fail++;
      $display("FAIL rel_fetch_done got=%0d cycles exp<60", n);
    end
  endtask

  task automatic test_single_fetch();
    bit ok, mir;
    logic dv, we;
    logic [3:0] be;
    logic [31:0] rd, ma, e;
    exp_f.push_back(mdata(32'h100));
    f_txn(32'h100, ok, rd, mir, dv, we, be, ma);
    e = exp_f.pop_front();
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL fetch_handshake got=timeout exp=done");
    end
    n_checks++;
    if (rd !== e) begin
      n_fail++;
      $display("FAIL fetch_rdata got=%h exp=%h", rd, e);
    end
    n_checks++;
    if (!mir || dv !== 1'b0) begin
      n_fail++;
      $display("FAIL fetch_valid got mir=%b dv=%b exp 1/0", mir, dv);
    end
    n_checks++;
    if (we !== 1'b0 || be !== 4'hF || ma !== 32'h100) begin
      n_fail++;
      $display("FAIL fetch_bus got we=%b be=%h a=%h exp 0/f/100",
        we, be, ma);
    end
  endtask

  task automatic test_simultaneous();
    bit okd, okf, mir;
    logic fv, mwe, dv, we;
    logic [3:0] mbe, be;
    logic [31:0] rdd, rdf, ma, mwd, maf, ed, ef;
    logic [1:0] eg;
    apply_reset();
    obs_gnt.delete();
    gaps.delete();
    mon_en = 1'b1;
    exp_gnt.push_back(GNT_D);
    exp_gnt.push_back(GNT_F);
    exp_d.push_back(mdata(32'h200));
    exp_f.push_back(mdata(32'h180));
    fork
      d_txn(1'b1, 32'h200, 32'h1234_5678, 4'b0011,
            okd, rdd, fv, mwe, ma, mwd, mbe);
      f_txn(32'h180, okf, rdf, mir, dv, we, be, maf);
    join
    mon_en = 1'b0;
    ed = exp_d.pop_front();
    ef = exp_f.pop_front();
    n_checks++;
    if (!okd || !okf) begin
      n_fail++;
      $display("FAIL sim_handshake got d=%b f=%b exp 1/1", okd, okf);
    end
    n_checks++;
    if ({mwe, ma, mwd, mbe} !== {1'b1, 32'h200, 32'h1234_5678, 4'b0011}) begin
      n_fail++;
      $display("FAIL sim_store_bus got we=%b a=%h wd=%h be=%b", mwe, ma, mwd, mbe);
    end
    n_checks++;
    if (rdd !== ed || rdf !== ef || fv !== 1'b0) begin
      n_fail++;
      $display("FAIL sim_rdata got d=%h f=%h fv=%b exp %h/%h/0",
        rdd, rdf, fv, ed, ef);
    end
    n_checks++;
    if (obs_gnt.size() != 2) begin
      n_fail++;
      $display("FAIL sim_grant_cnt got=%0d exp=2", obs_gnt.size());
    end
    while (exp_gnt.size() > 0 && obs_gnt.size() > 0) begin
      eg = exp_gnt.pop_front();
      n_checks++;
      if (obs_gnt[0] !== eg) begin
        n_fail++;
        $display("FAIL sim_grant_order got=%b exp=%b", obs_gnt[0], eg);
      end
      void'(obs_gnt.pop_front());
    end
    exp_gnt.delete();
  endtask

  task automatic test_fairness();
    logic [1:0] eg;
    int g;
    apply_reset();
    obs_gnt.delete();
    gaps.delete();
    exp_gnt.delete();
    for (int i = 0; i < 3; i++) begin
      exp_gnt.push_back(GNT_D);
      exp_gnt.push_back(GNT_F);
    end
    mon_en = 1'b1;
    fork
      begin
        bit ok;
        logic fv, mwe;
        logic [3:0] mbe;
        logic [31:0] rd, ma, mwd, e, a;
        for (int i = 0; i < 3; i++) begin
          a = 32'h1000 + 32'(i * 4);
          exp_d.push_back(mdata(a));
          d_txn(1'b0, a, 32'h0, 4'hF, ok, rd, fv, mwe, ma, mwd, mbe);
          e = exp_d.pop_front();
          n_checks++;
          if (!ok || rd !== e) begin
            n_fail++;
            $display("FAIL fair_d_rdata got=%h ok=%b exp=%h", rd, ok, e);
          end
        end
      end
      begin
        bit ok, mir;
        logic dv, we;
        logic [3:0] be;
        logic [31:0] rd, ma, e, a;
        for (int i = 0; i < 3; i++) begin
          a = 32'h2000 + 32'(i * 4);
          exp_f.push_back(mdata(a));
          f_txn(a, ok, rd, mir, dv, we, be, ma);
          e = exp_f.pop_front();
          n_checks++;
          if (!ok || rd !== e) begin
            n_fail++;
            $display("FAIL fair_f_rdata got=%h ok=%b exp=%h", rd, ok, e);
          end
        end
      end
    join
    repeat (2) @(negedge clk);
    mon_en = 1'b0;
    n_checks++;
    if (obs_gnt.size() != 6) begin
      n_fail++;
      $display("FAIL fair_grant_cnt got=%0d exp=6", obs_gnt.size());
    end
    while (exp_gnt.size() > 0 && obs_gnt.size() > 0) begin
      eg = exp_gnt.pop_front();
      n_checks++;
      if (obs_gnt[0] !== eg) begin
        n_fail++;
        $display("FAIL fair_grant_order got=%b exp=%b", obs_gnt[0], eg);
      end
      void'(obs_gnt.pop_front());
    end
    while (gaps.size() > 0) begin
      g = gaps.pop_front();
      n_checks++;
      if (g != 2) begin
        n_fail++;
        $display("FAIL fair_gap got=%0d exp=2", g);
      end
    end
    exp_gnt.delete();
  endtask

  task automatic test_timeout();
    int hi, n;
    bit bad;
    apply_reset();
    mem_silent = 1'b1;
    mem_valid = 1'b0;
    f_addr = 32'h300;
    f_req = 1'b1;
    hi = 0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (mem_req) hi++;
    end while (n < 20 && !(hi > 0 && !mem_req));
    n_checks++;
    if (hi != 4) begin
      n_fail++;
      $display("FAIL to_req_cycles got=%0d exp=4", hi);
    end
    n_checks++;
    if (f_valid !== 1'b1 || rdata !== 32'h0 || err_timeout !== 1'b1) begin
      n_fail++;
      $display("FAIL to_abort got fv=%b rd=%h err=%b exp 1/0/1",
        f_valid, rdata, err_timeout);
    end
    mem_rdata = 32'hCAFE_F00D;
    mem_valid = 1'b1;
    @(negedge clk);
    n_checks++;
    if (f_valid !== 1'b1 || rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL to_late_rdata got fv=%b rd=%h exp 1/0", f_valid, rdata);
    end
    f_req = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (grant !== 2'b00 || mem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL to_idle got gnt=%b req=%b exp 00/0", grant, mem_req);
    end
    bad = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (f_valid || d_valid) bad = 1'b1;
    end
    n_checks++;
    if (bad) begin
      n_fail++;
      $display("FAIL to_late_valid got pulse exp none");
    end
    mem_valid = 1'b0;
    mem_silent = 1'b0;
    n_checks++;
    if (err_timeout !== 1'b1) begin
      n_fail++;
      $display("FAIL to_err_sticky got=%b exp=1", err_timeout);
    end
  endtask

  task automatic test_async_reset();
    int n;
    d_we = 1'b0;
    d_addr = 32'h400;
    d_byte_enable = 4'hF;
    d_req = 1'b1;
    n = 0;
    while (n < 60 && !d_valid) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (d_valid !== 1'b1 || grant !== GNT_D || err_timeout !== 1'b1) begin
      n_fail++;
      $display("FAIL ar_pre got dv=%b gnt=%b err=%b exp 1/10/1",
        d_valid, grant, err_timeout);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({mem_req, d_valid, err_timeout} !== 3'b000) begin
      n_fail++;
      $display("FAIL ar_drop got req=%b dv=%b err=%b exp 0/0/0",
        mem_req, d_valid, err_timeout);
    end
    n_checks++;
    if (grant !== 2'b00) begin
      n_fail++;
      $display("FAIL ar_grant got=%b exp=00", grant);
    end
    d_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    mem_silent = 1'b0;
    mon_en = 1'b0;
    rst_n = 1'b0;
    f_req = 1'b0;
    f_addr = '0;
    d_req = 1'b0;
    d_we = 1'b0;
    d_addr = '0;
    d_wdata = '0;
    d_byte_enable = '0;
    test_reset();
    test_single_fetch();
    test_simultaneous();
    test_fairness();
    test_timeout();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures",
      n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares the single core memory port between two requesters: the fetch unit (port F, read-only instruction fetch) and the decode unit's LSU interface (port D, load/store). Both sides use the core's 4-phase req/valid handshake (req high -> valid high -> req low -> valid low). The block grants one requester at a time with round-robin fairness, muxes address/data/byte-enable to memory, and routes the response back. A watchdog counter aborts a transaction that memory never acknowledges.

Parameters:
DATA_WIDTH, 32, data bus width
ADDR_WIDTH, 32, address width
BYTE_DATA_WIDTH, 4, byte-enable width (DATA_WIDTH/8)
TIMEOUT, 255, max cycles in a grant state with mem_valid low before abort; 0 disables the watchdog
CNT_WIDTH, 8, watchdog counter width, must hold TIMEOUT

Ports:
clk  in  1  core clock
rst_n  in  1  reset, asynchronous, active-low
f_req  in  1  fetch request (held until f_valid)
f_addr  in  ADDR_WIDTH  fetch address
f_valid  out  1  fetch response valid
d_req  in  1  LSU request (held until d_valid)
d_we  in  1  LSU write enable
d_addr  in  ADDR_WIDTH  LSU address
d_wdata  in  DATA_WIDTH  LSU store data
d_byte_enable  in  BYTE_DATA_WIDTH  LSU byte enables
d_valid  out  1  LSU response valid
rdata  out  DATA_WIDTH  read data, shared by both requesters
mem_req  out  1  memory request
mem_we  out  1  memory write enable
mem_addr  out  ADDR_WIDTH  memory address
mem_wdata  out  DATA_WIDTH  memory store data
mem_byte_enable  out  BYTE_DATA_WIDTH  memory byte enables
mem_rdata  in  DATA_WIDTH  memory read data
mem_valid  in  1  memory response valid
grant  out  2  current grant, one-hot {D,F}; 00 when idle
err_timeout  out  1  sticky watchdog flag, cleared only by reset

Behaviour:
- Reset (async assert, sync deassert): state S_IDLE; last_grant = F (so D wins the first tie); all outputs 0; watchdog 0; err_timeout 0. Reset mid-transaction drops mem_req at once; memory must tolerate an abandoned handshake.
- States: S_IDLE, S_GRANT_F, S_GRANT_D, S_RELEASE, S_ABORT.
- S_IDLE: only f_req -> S_GRANT_F; only d_req -> S_GRANT_D; both -> the port not equal to last_grant. Grant is registered: mem_req rises the cycle after the request is first seen (1-cycle arbitration latency).
- S_GRANT_x: mem_req = x_req; mem_addr/we/wdata/byte_enable muxed combinationally from the granted port (F forces we = 0 and byte_enable = all ones). x_valid = mem_valid. rdata = mem_rdata. The ungranted port's valid stays 0. When x_req = 0 and mem_valid = 0 after a completed handshake -> S_RELEASE and set last_grant = x.
- S_RELEASE: one dead cycle with all outputs 0 and grant = 00 -> S_IDLE. Back-to-back requests from one port therefore cost 2 idle cycles; alternating ports are serviced fairly.
- Watchdog: counts cycles in S_GRANT_x while mem_valid has not yet been seen; resets on state entry. When count == TIMEOUT -> S_ABORT, set err_timeout, drop mem_req.
- S_ABORT: drives x_valid = 1 with rdata = 0 until x_req falls, then -> S_RELEASE. Any late mem_valid is ignored.
- A request that drops before valid (protocol violation) is treated as completion once mem_valid = 0.
- grant is a registered one-hot decode of the state.

Decomposition:
- Shared package/config: state encodings (S_IDLE..S_ABORT), grant one-hot constants GNT_F = 2'b01 and GNT_D = 2'b10.
- One natural sub-module: rr_arbiter2, a 2-input round-robin pick with a last_grant register and update strobe. The FSM, mux, and watchdog stay in the top level.

Test Plan:
- Reset: hold rst_n = 0 with f_req = 1 -> all outputs 0, grant = 00. Release -> mem_req = 1 two cycles after the first rising clk edge, grant = 01.
- Single fetch: f_addr = 0x100, memory returns 0xDEADBEEF after 3 cycles -> f_valid mirrors mem_valid, rdata = 0xDEADBEEF, mem_we = 0, mem_byte_enable = 4'b1111, d_valid stays 0.
- Simultaneous f_req and d_req after reset -> D granted first (store: d_we = 1, d_addr = 0x200, d_wdata = 0x12345678, be = 4'b0011 appear on the mem_* outputs); after D releases, F is granted.
- Fairness: both requesters re-request continuously for 6 transactions -> grant sequence D, F, D, F, D, F with one S_RELEASE cycle between each.
- Timeout with TIMEOUT = 4 and memory silent -> mem_req drops after 4 cycles, err_timeout = 1, f_valid = 1 with rdata = 0. After f_req falls -> S_IDLE. A late mem_valid causes no valid pulse.
- Async reset asserted mid-S_GRANT_D -> mem_req and d_valid drop before the next clk edge; err_timeout cleared.
